// File: rtl/fm_sb_rd_sched_pkg.sv
// Spy-buffer bank constants, per-buffer entry widths and the readout scheduler state type.
package fm_sb_rd_sched_pkg;

  localparam int sb_mapped_n = 108;
  localparam int axi_dw      = 32;
  localparam int mon_dw_max  = 256;

  typedef logic [sb_mapped_n-1:0][8:0] sb_dw_arr_t;
  typedef logic [sb_mapped_n-1:0][3:0] sb_nbeats_arr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_POP,
    ST_WAIT,
    ST_SHIFT
  } sb_sched_state_t;

  // Padded entry width per buffer; the layout repeats every four indices.
  function automatic sb_dw_arr_t gen_sb_dw();
    sb_dw_arr_t a;
    for (int i = 0; i < sb_mapped_n; i++) begin
      case (i % 4)
        0:       a[i] = 9'd256;
        1:       a[i] = 9'd64;
        2:       a[i] = 9'd32;
        default: a[i] = 9'd128;
      endcase
    end
    return a;
  endfunction

  localparam sb_dw_arr_t sb_dw = gen_sb_dw();

  // Beats per entry: 1, 2, 4 or 8.
  function automatic sb_nbeats_arr_t gen_sb_nbeats();
    sb_nbeats_arr_t a;
    for (int i = 0; i < sb_mapped_n; i++) begin
      a[i] = 4'(sb_dw[i] / axi_dw);
    end
    return a;
  endfunction

  localparam sb_nbeats_arr_t sb_nbeats = gen_sb_nbeats();

endpackage

// File: rtl/fm_sb_rr_arb.sv
// Round-robin priority search: first set request at or above ptr_i, wrapping at N.
module fm_sb_rr_arb
  import fm_sb_rd_sched_pkg::*;
#(
  parameter int N     = 108,
  parameter int IDX_W = 7
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found_o && req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fm_sb_rd_sched.sv
// Spy-buffer readout scheduler: round-robin pop, wait for muxed data, serialize into beats.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | waiting for enable and an eligible request
// ST_ARB   | round-robin search, register winner
// ST_POP   | one-cycle pop strobe, load beat count, arm timer
// ST_WAIT  | waiting for rd_vld or timeout
// ST_SHIFT | emitting beats on the output stream
module fm_sb_rd_sched
  import fm_sb_rd_sched_pkg::*;
#(
  parameter int SB_N       = 108,
  parameter int AXI_DW     = 32,
  parameter int MON_DW_MAX = 256,
  parameter int IDX_W      = 7,
  parameter int TMO_CYC    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [SB_N-1:0]       sb_mask,
  input  logic [SB_N-1:0]       sb_req,
  output logic [SB_N-1:0]       sb_pop,
  output logic [IDX_W-1:0]      sel_idx,
  input  logic [MON_DW_MAX-1:0] rd_data,
  input  logic                  rd_vld,
  output logic [AXI_DW-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [IDX_W-1:0]      m_src,
  output logic                  err_tmo,
  input  logic                  err_clr,
  output logic [31:0]           beat_cnt_tot
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  sb_sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [3:0]            nbeats_q, nbeats_d;
  logic [2:0]            beat_rem_q, beat_rem_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [MON_DW_MAX-1:0] shreg_q, shreg_d;
  logic [SB_N-1:0]       sb_pop_q, sb_pop_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  err_tmo_q, err_tmo_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;

  logic [SB_N-1:0]       elig;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_found;
  logic                  hs;
  logic                  tmo_hit;

  assign elig = sb_req & sb_mask;
  assign hs   = (state_q == ST_SHIFT) && m_valid_q && m_ready;

  fm_sb_rr_arb #(
    .N     (SB_N),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  // Sequencing FSM and datapath next-state.
  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    rr_ptr_d   = rr_ptr_q;
    nbeats_d   = nbeats_q;
    beat_rem_d = beat_rem_q;
    tmo_cnt_d  = tmo_cnt_q;
    shreg_d    = shreg_q;
    sb_pop_d   = '0;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    tmo_hit    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && |elig) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (arb_found) begin
          sel_idx_d = arb_idx;
          sb_pop_d  = {{(SB_N-1){1'b0}}, 1'b1} << arb_idx;
          state_d   = ST_POP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POP: begin
        nbeats_d  = sb_nbeats[sel_idx_q];
        tmo_cnt_d = TMO_W'(TMO_CYC - 1);
        // Pointer moves here so a buffer that later times out still loses priority.
        rr_ptr_d  = (sel_idx_q == IDX_W'(SB_N - 1)) ? '0 : sel_idx_q + 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_vld) begin
          shreg_d    = rd_data;
          beat_rem_d = 3'(nbeats_q - 4'd1);
          m_valid_d  = 1'b1;
          m_last_d   = (nbeats_q == 4'd1);
          state_d    = ST_SHIFT;
        end else if (tmo_cnt_q == '0) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (hs) begin
          shreg_d    = shreg_q >> AXI_DW;
          beat_rem_d = beat_rem_q - 1'b1;
          m_last_d   = (beat_rem_q == 3'd1);
          if (beat_rem_q == 3'd0) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky timeout flag and beat counter; a timeout beats a clear, a clear beats a beat.
  always_comb begin
    err_tmo_d  = tmo_hit ? 1'b1 : (err_clr ? 1'b0 : err_tmo_q);
    beat_cnt_d = err_clr ? 32'd0 : (hs ? beat_cnt_q + 32'd1 : beat_cnt_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_idx_q  <= '0;
      rr_ptr_q   <= '0;
      nbeats_q   <= '0;
      beat_rem_q <= '0;
      tmo_cnt_q  <= '0;
      shreg_q    <= '0;
      sb_pop_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      err_tmo_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      nbeats_q   <= nbeats_d;
      beat_rem_q <= beat_rem_d;
      tmo_cnt_q  <= tmo_cnt_d;
      shreg_q    <= shreg_d;
      sb_pop_q   <= sb_pop_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      err_tmo_q  <= err_tmo_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sb_pop       = sb_pop_q;
  assign sel_idx      = sel_idx_q;
  assign m_src        = sel_idx_q;
  assign m_data       = shreg_q[AXI_DW-1:0];
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign err_tmo      = err_tmo_q;
  assign beat_cnt_tot = beat_cnt_q;

endmodule

// File: tb/tb_fm_sb_rd_sched.sv
// Directed bench for the spy-buffer readout scheduler.
module tb_fm_sb_rd_sched;

  localparam int SB_N       = 108;
  localparam int AXI_DW     = 32;
  localparam int MON_DW_MAX = 256;
  localparam int IDX_W      = 7;
  localparam int TMO_CYC    = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enable;
  logic [SB_N-1:0]       sb_mask;
  logic [SB_N-1:0]       sb_req;
  logic [SB_N-1:0]       sb_pop;
  logic [IDX_W-1:0]      sel_idx;
  logic [MON_DW_MAX-1:0] rd_data;
  logic                  rd_vld;
  logic [AXI_DW-1:0]     m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic [IDX_W-1:0]      m_src;
  logic                  err_tmo;
  logic                  err_clr;
  logic [31:0]           beat_cnt_tot;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  fm_sb_rd_sched #(
    .SB_N       (SB_N),
    .AXI_DW     (AXI_DW),
    .MON_DW_MAX (MON_DW_MAX),
    .IDX_W      (IDX_W),
    .TMO_CYC    (TMO_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sb_mask      (sb_mask),
    .sb_req       (sb_req),
    .sb_pop       (sb_pop),
    .sel_idx      (sel_idx),
    .rd_data      (rd_data),
    .rd_vld       (rd_vld),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .m_src        (m_src),
    .err_tmo      (err_tmo),
    .err_clr      (err_clr),
    .beat_cnt_tot (beat_cnt_tot)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SB_N-1:0] oh(input int k);
    logic [SB_N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) for a pop strobe; returns zero if none arrives.
  task automatic wait_pop(output logic [SB_N-1:0] pv);
    pv = '0;
    for (int c = 0; c < 20 && pv == '0; c++) begin
      tick();
      pv = sb_pop;
    end
  endtask

  // Wait for a pop, return rd_data lat cycles later, drain with m_ready high.
  task automatic serve_entry(input int lat, input logic [MON_DW_MAX-1:0] d,
                             output logic [SB_N-1:0] pv, output bit ok);
    ok = 1'b0;
    wait_pop(pv);
    if (pv == '0) return;
    repeat (lat) tick();
    rd_vld  = 1'b1;
    rd_data = d;
    tick();
    rd_vld  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (m_valid && m_ready && m_last) begin
        tick();
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    enable  = 1'b1;
    sb_mask = '1;
    sb_mask[106] = 1'b0;
    sb_mask[107] = 1'b0;
    sb_req  = '0;
    rd_data = '0;
    rd_vld  = 1'b0;
    m_ready = 1'b1;
    err_clr = 1'b0;
    #23;
    n_chk++;
    if (sb_pop !== '0 || sel_idx !== '0 || m_src !== '0) begin
      n_err++;
      $display("FAIL reset_idx: pop=%0h sel=%0d src=%0d want 0", sb_pop, sel_idx, m_src);
    end
    n_chk++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0) begin
      n_err++;
      $display("FAIL reset_stream: valid=%b last=%b data=%0h want 0", m_valid, m_last, m_data);
    end
    n_chk++;
    if (err_tmo !== 1'b0 || beat_cnt_tot !== 32'd0) begin
      n_err++;
      $display("FAIL reset_status: err_tmo=%b cnt=%0d want 0", err_tmo, beat_cnt_tot);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [MON_DW_MAX-1:0] d;
    logic [31:0] w [4];
    w[0] = 32'hAAAAAAAA;
    w[1] = 32'hBBBBBBBB;
    w[2] = 32'hCCCCCCCC;
    w[3] = 32'hDDDDDDDD;
    d = {{4{32'hFFFFFFFF}}, w[3], w[2], w[1], w[0]};
    sb_req = oh(3);
    tick();
    n_chk++;
    if (sb_pop !== '0) begin
      n_err++;
      $display("FAIL single_pop_early: pop=%0h want 0 at t+1", sb_pop);
    end
    tick();
    n_chk++;
    if (sb_pop !== oh(3) || sel_idx !== 7'd3) begin
      n_err++;
      $display("FAIL single_pop: pop=%0h sel=%0d want bit3 sel=3 at t+2", sb_pop, sel_idx);
    end
    sb_req = '0;
    tick();
    n_chk++;
    if (sb_pop !== '0) begin
      n_err++;
      $display("FAIL single_pop_width: pop=%0h want 0 after one cycle", sb_pop);
    end
    tick();
    rd_vld  = 1'b1;
    rd_data = d;
    tick();
    rd_vld  = 1'b0;
    rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (m_valid !== 1'b1 || m_data !== w[k] || m_last !== (k == 3) || m_src !== 7'd3) begin
        n_err++;
        $display("FAIL single_beat%0d: valid=%b data=%h last=%b src=%0d want 1 %h %b 3",
                 k, m_valid, m_data, m_last, m_src, w[k], (k == 3));
      end
      tick();
    end
    n_chk++;
    if (m_valid !== 1'b0 || beat_cnt_tot !== 32'd4) begin
      n_err++;
      $display("FAIL single_end: valid=%b cnt=%0d want 0 4", m_valid, beat_cnt_tot);
    end
  endtask

  task automatic test_round_robin();
    logic [SB_N-1:0] pv;
    bit ok;
    int exp_i [4];
    exp_i[0] = 0;
    exp_i[1] = 5;
    exp_i[2] = 0;
    exp_i[3] = 5;
    do_reset();
    sb_req = oh(0) | oh(5) | oh(107);
    for (int n = 0; n < 4; n++) begin
      serve_entry(1, {8{32'h5A5A0000 | 32'(n)}}, pv, ok);
      n_chk++;
      if (pv !== oh(exp_i[n]) || !ok) begin
        n_err++;
        $display("FAIL rr_pop%0d: pop=%0h done=%0d want bit%0d done=1", n, pv, ok, exp_i[n]);
      end
    end
    sb_req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [SB_N-1:0] pv;
    logic [MON_DW_MAX-1:0] d;
    int k;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++;
    if (beat_cnt_tot !== 32'd0) begin
      n_err++;
      $display("FAIL bp_clr: cnt=%0d want 0", beat_cnt_tot);
    end
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'hB0000000 | 32'(i);
    sb_req = oh(0);
    wait_pop(pv);
    sb_req = '0;
    n_chk++;
    if (pv !== oh(0)) begin
      n_err++;
      $display("FAIL bp_pop: pop=%0h want bit0", pv);
    end
    tick();
    rd_vld  = 1'b1;
    rd_data = d;
    tick();
    rd_vld  = 1'b0;
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      m_ready = (c % 3 == 0);
      n_chk++;
      if (m_valid !== 1'b1 || m_data !== (32'hB0000000 | 32'(k)) || m_last !== (k == 7)) begin
        n_err++;
        $display("FAIL bp_beat%0d: valid=%b data=%h last=%b want 1 %h %b",
                 k, m_valid, m_data, m_last, 32'hB0000000 | 32'(k), (k == 7));
        break;
      end
      if (m_ready) k++;
      tick();
    end
    m_ready = 1'b1;
    n_chk++;
    if (k !== 8 || beat_cnt_tot !== 32'd8 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_end: beats=%0d cnt=%0d valid=%b want 8 8 0", k, beat_cnt_tot, m_valid);
    end
  endtask

  task automatic test_timeout();
    logic [SB_N-1:0] pv;
    bit ok;
    bit seen;
    sb_req = oh(10);
    wait_pop(pv);
    n_chk++;
    if (pv !== oh(10)) begin
      n_err++;
      $display("FAIL tmo_pop: pop=%0h want bit10", pv);
    end
    sb_req = oh(2) | oh(10) | oh(12);
    seen = 1'b0;
    for (int c = 0; c < TMO_CYC; c++) begin
      tick();
      seen = seen | m_valid | (|sb_pop);
    end
    n_chk++;
    if (err_tmo !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_early: err_tmo=%b want 0 during 16 wait cycles", err_tmo);
    end
    tick();
    n_chk++;
    if (err_tmo !== 1'b1 || seen) begin
      n_err++;
      $display("FAIL tmo_flag: err_tmo=%b stray_activity=%b want 1 0", err_tmo, seen);
    end
    serve_entry(2, {8{32'h0C0C0C0C}}, pv, ok);
    sb_req = '0;
    n_chk++;
    if (pv !== oh(12) || !ok) begin
      n_err++;
      $display("FAIL tmo_next: pop=%0h done=%0d want bit12 done=1", pv, ok);
    end
    n_chk++;
    if (err_tmo !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_sticky: err_tmo=%b want 1", err_tmo);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++;
    if (err_tmo !== 1'b0 || beat_cnt_tot !== 32'd0) begin
      n_err++;
      $display("FAIL tmo_clr: err_tmo=%b cnt=%0d want 0 0", err_tmo, beat_cnt_tot);
    end
  endtask

  task automatic test_disable_mid();
    logic [SB_N-1:0] pv;
    bit seen;
    sb_req = oh(13);
    wait_pop(pv);
    n_chk++;
    if (pv !== oh(13)) begin
      n_err++;
      $display("FAIL dis_pop: pop=%0h want bit13", pv);
    end
    tick();
    rd_vld  = 1'b1;
    rd_data = {{6{32'hEEEEEEEE}}, 32'h22222222, 32'h11111111};
    tick();
    rd_vld  = 1'b0;
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 32'h11111111 || m_last !== 1'b0) begin
      n_err++;
      $display("FAIL dis_beat1: valid=%b data=%h last=%b want 1 11111111 0", m_valid, m_data, m_last);
    end
    tick();
    enable = 1'b0;
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 32'h22222222 || m_last !== 1'b1 || m_src !== 7'd13) begin
      n_err++;
      $display("FAIL dis_beat2: valid=%b data=%h last=%b src=%0d want 1 22222222 1 13",
               m_valid, m_data, m_last, m_src);
    end
    tick();
    seen = m_valid;
    for (int c = 0; c < 30; c++) begin
      tick();
      seen = seen | m_valid | (|sb_pop);
    end
    n_chk++;
    if (seen) begin
      n_err++;
      $display("FAIL dis_hold: activity=%b want 0 while disabled", seen);
    end
    sb_req = '0;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [SB_N-1:0] pv;
    bit ok;
    sb_req = oh(20);
    wait_pop(pv);
    sb_req = '0;
    tick();
    rd_vld  = 1'b1;
    rd_data = {8{32'h77777777}};
    tick();
    rd_vld  = 1'b0;
    tick();
    n_chk++;
    if (m_valid !== 1'b1 || beat_cnt_tot === 32'd0) begin
      n_err++;
      $display("FAIL rstm_pre: valid=%b cnt=%0d want 1 nonzero", m_valid, beat_cnt_tot);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0) begin
      n_err++;
      $display("FAIL rstm_stream: valid=%b last=%b data=%h want 0", m_valid, m_last, m_data);
    end
    n_chk++;
    if (sb_pop !== '0 || sel_idx !== '0 || m_src !== '0 || err_tmo !== 1'b0 || beat_cnt_tot !== 32'd0) begin
      n_err++;
      $display("FAIL rstm_regs: pop=%0h sel=%0d src=%0d err=%b cnt=%0d want 0",
               sb_pop, sel_idx, m_src, err_tmo, beat_cnt_tot);
    end
    sb_req = oh(0) | oh(20);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    serve_entry(1, {8{32'h01010101}}, pv, ok);
    sb_req = '0;
    n_chk++;
    if (pv !== oh(0) || !ok) begin
      n_err++;
      $display("FAIL rstm_first: pop=%0h done=%0d want bit0 done=1", pv, ok);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_disable_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
